// File: rtl/btn_press_cond.sv
// ---------------------------------------------------------------------------
// btn_press_cond
//
// Conditions the raw mode-select push button before it reaches the mode
// selector. The button is synchronised, debounced on a millisecond tick and
// turned into a clean level plus press, release and long-press events. The
// same power switch that gates the mode selector also gates this block, so
// downstream logic only ever sees clean, power-qualified button activity.
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency; TICK_DIV = CLK_FREQ_HZ/1000 (>= 2)
//   DEBOUNCE_MS  ms the synchronised input must hold a new level (>= 1)
//   LONG_MS      hold time in ms at which long_pulse fires
//   HOLD_W       width of hold_ms
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   power          power switch, low = block idle
//   btn_raw        raw bouncing asynchronous button, high = pressed
//   btn_level      debounced button level
//   press_pulse    one-clk pulse on an accepted press
//   release_pulse  one-clk pulse on an accepted release
//   hold_ms        saturating ms count since the accepted press
//   long_pulse     one-clk pulse when hold_ms first reaches LONG_MS
// ---------------------------------------------------------------------------
module btn_press_cond #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 500,
  parameter int HOLD_W      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              power,
  input  logic              btn_raw,
  output logic              btn_level,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic [HOLD_W-1:0] hold_ms,
  output logic              long_pulse
);

  localparam int TICK_DIV = CLK_FREQ_HZ / 1000;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DCNT_W   = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
  localparam logic [HOLD_W-1:0] LONG_VAL  = HOLD_W'(LONG_MS);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DCNT_W-1:0] dcnt;
  logic [DCNT_W-1:0] dcnt_next;
  logic              press_evt;
  logic              release_evt;

  logic              sync_meta;
  logic              btn_s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              hold_inc;

  // Two-flop synchroniser for the asynchronous button. It keeps running while
  // power is low so the FSM sees a settled level the moment power returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      btn_s     <= 1'b0;
    end else begin
      sync_meta <= btn_raw;
      btn_s     <= sync_meta;
    end
  end

  // Free-running millisecond time base. Only reset touches it, so the tick
  // phase is independent of button and power activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Debounce decisions. A WAIT state only completes when the synchronised
  // input has held the candidate level through DEBOUNCE_MS ticks; any return
  // to the old level aborts the wait, even on the completing tick. Power low
  // overrides everything and drops straight back to RELEASED without an
  // event, so the mode logic never sees a release caused by power loss.
  always_comb begin
    state_next  = state;
    dcnt_next   = dcnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    if (!power) begin
      state_next = RELEASED;
      dcnt_next  = '0;
    end else begin
      case (state)
        RELEASED: begin
          if (btn_s) begin
            state_next = PRESS_WAIT;
            dcnt_next  = '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_next = RELEASED;
            dcnt_next  = '0;
          end else if (tick) begin
            if (dcnt == DCNT_LAST) begin
              state_next = PRESSED;
              dcnt_next  = '0;
              press_evt  = 1'b1;
            end else begin
              dcnt_next = dcnt + 1'b1;
            end
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_next = RELEASE_WAIT;
            dcnt_next  = '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_next = PRESSED;
            dcnt_next  = '0;
          end else if (tick) begin
            if (dcnt == DCNT_LAST) begin
              state_next  = RELEASED;
              dcnt_next   = '0;
              release_evt = 1'b1;
            end else begin
              dcnt_next = dcnt + 1'b1;
            end
          end
        end
        default: begin
          state_next = RELEASED;
          dcnt_next  = '0;
        end
      endcase
    end
  end

  // FSM register plus the level and edge outputs derived from the transition,
  // registered so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      dcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      dcnt          <= dcnt_next;
      btn_level     <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      press_pulse   <= press_evt;
      release_pulse <= release_evt;
    end
  end

  assign hold_inc = btn_level && tick && (hold_ms != HOLD_MAX);

  // Hold timer. It restarts with each accepted press, counts ms while the
  // debounced level is high (a glitch through RELEASE_WAIT does not restart
  // it) and saturates. Because it only restarts on a press and never wraps,
  // the increment that lands on LONG_MS happens at most once per press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_ms    <= '0;
      long_pulse <= 1'b0;
    end else if (!power) begin
      hold_ms    <= '0;
      long_pulse <= 1'b0;
    end else if (press_evt) begin
      hold_ms    <= '0;
      long_pulse <= 1'b0;
    end else if (hold_inc) begin
      hold_ms    <= hold_ms + 1'b1;
      long_pulse <= ((hold_ms + 1'b1) == LONG_VAL);
    end else begin
      long_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_press_cond.sv
// ---------------------------------------------------------------------------
// tb_btn_press_cond
//
// Self-checking bench for btn_press_cond with a 10-clk millisecond, 3 ms
// debounce, 8 ms long press and a 4-bit hold counter. A behavioural model
// that thinks in terms of accepted level / pending candidate runs alongside
// the DUT and every output is compared after each clock edge. Directed
// scenarios add event-count and latency checks on top.
// ---------------------------------------------------------------------------
module tb_btn_press_cond;

  localparam int CLK_FREQ_HZ = 10000;
  localparam int TICK_DIV    = CLK_FREQ_HZ / 1000;
  localparam int DEBOUNCE_MS = 3;
  localparam int LONG_MS     = 8;
  localparam int HOLD_W      = 4;
  localparam int HOLD_MAX    = (1 << HOLD_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              power = 1'b0;
  logic              btn_raw = 1'b0;
  logic              btn_level;
  logic              press_pulse;
  logic              release_pulse;
  logic [HOLD_W-1:0] hold_ms;
  logic              long_pulse;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_sync0, m_sync1, m_cyc;
  int m_acc, m_pend, m_ticks, m_hold;
  int m_press, m_release, m_long;

  int press_seen = 0;
  int release_seen = 0;
  int long_seen = 0;
  int level_high = 0;
  int level_low = 0;
  int last_press = 0;
  int last_release = 0;

  btn_press_cond #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .DEBOUNCE_MS (DEBOUNCE_MS),
    .LONG_MS     (LONG_MS),
    .HOLD_W      (HOLD_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .power         (power),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .hold_ms       (hold_ms),
    .long_pulse    (long_pulse)
  );

  // 10 time-unit system clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d cycle=%0d", tag, observed, expected, cyc);
    end
  endtask

  // Model state after reset: nothing accepted, nothing pending, tick phase 0.
  task automatic modelReset();
    m_sync0 = 0; m_sync1 = 0; m_cyc = 0;
    m_acc = 0; m_pend = 0; m_ticks = 0; m_hold = 0;
    m_press = 0; m_release = 0; m_long = 0;
  endtask

  // One clock of the reference behaviour: a candidate level different from
  // the accepted one must survive DEBOUNCE_MS ticks to be accepted; the hold
  // counter counts ms while the accepted level is high.
  task automatic modelStep();
    int bs;
    int tck;
    int acc_old;
    bs = m_sync1;
    tck = ((m_cyc % TICK_DIV) == (TICK_DIV - 1)) ? 1 : 0;
    acc_old = m_acc;
    m_press = 0; m_release = 0; m_long = 0;
    if (!power) begin
      m_acc = 0; m_pend = 0; m_ticks = 0; m_hold = 0;
    end else begin
      if (m_pend == 0) begin
        if (bs != m_acc) begin
          m_pend = 1;
          m_ticks = 0;
        end
      end else if (bs == m_acc) begin
        m_pend = 0;
      end else if (tck == 1) begin
        if (m_ticks == DEBOUNCE_MS - 1) begin
          m_acc = bs;
          m_pend = 0;
          if (bs == 1) m_press = 1;
          else m_release = 1;
        end else begin
          m_ticks++;
        end
      end
      if (m_press == 1) begin
        m_hold = 0;
      end else if (acc_old == 1 && tck == 1 && m_hold < HOLD_MAX) begin
        m_hold++;
        if (m_hold == LONG_MS) m_long = 1;
      end
    end
    m_sync1 = m_sync0;
    m_sync0 = btn_raw;
    m_cyc++;
  endtask

  // Compare all outputs against the model and log observed events.
  task automatic compareAll();
    checkOutput("btn_level", btn_level, m_acc);
    checkOutput("press_pulse", press_pulse, m_press);
    checkOutput("release_pulse", release_pulse, m_release);
    checkOutput("hold_ms", hold_ms, m_hold);
    checkOutput("long_pulse", long_pulse, m_long);
    if (press_pulse) begin press_seen++; last_press = cyc; end
    if (release_pulse) begin release_seen++; last_release = cyc; end
    if (long_pulse) long_seen++;
    if (btn_level) level_high++;
    else level_low++;
  endtask

  // Drive one input pattern for n clocks; starts and ends on a falling edge.
  task automatic applyStimulus(input logic b, input logic p, input int n);
    for (int i = 0; i < n; i++) begin
      btn_raw = b;
      power = p;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_level"}, btn_level, 0);
    checkOutput({tag, "_press"}, press_pulse, 0);
    checkOutput({tag, "_release"}, release_pulse, 0);
    checkOutput({tag, "_hold"}, hold_ms, 0);
    checkOutput({tag, "_long"}, long_pulse, 0);
  endtask

  initial begin
    int edge_c, p0, r0, l0, lh0, ll0, found, h0;

    // Reset with the button held and power on: outputs stay 0 throughout.
    @(negedge clk);
    power = 1'b1;
    btn_raw = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkAllZero("reset");
      @(negedge clk);
    end
    modelReset();
    rst_n = 1'b1;
    edge_c = cyc;
    p0 = press_seen;
    applyStimulus(1'b1, 1'b1, 40);
    checkOutput("reset_press_count", press_seen - p0, 1);
    checkOutput("reset_press_latency_ok",
                (last_press - edge_c >= 23 && last_press - edge_c <= 32) ? 1 : 0, 1);
    applyStimulus(1'b0, 1'b1, 40);

    // Clean press and release.
    edge_c = cyc;
    p0 = press_seen;
    applyStimulus(1'b1, 1'b1, 60);
    checkOutput("clean_press_count", press_seen - p0, 1);
    checkOutput("clean_press_latency_ok",
                (last_press - edge_c >= 23 && last_press - edge_c <= 32) ? 1 : 0, 1);
    checkOutput("clean_level_high", btn_level, 1);
    edge_c = cyc;
    r0 = release_seen;
    applyStimulus(1'b0, 1'b1, 40);
    checkOutput("clean_release_count", release_seen - r0, 1);
    checkOutput("clean_release_latency_ok",
                (last_release - edge_c >= 23 && last_release - edge_c <= 32) ? 1 : 0, 1);
    checkOutput("clean_level_low", btn_level, 0);

    // Bounce shorter than the debounce window never gets accepted.
    p0 = press_seen;
    lh0 = level_high;
    for (int k = 0; k < 5; k++) applyStimulus((k % 2) == 0, 1'b1, 15);
    applyStimulus(1'b0, 1'b1, 40);
    checkOutput("bounce_press_count", press_seen - p0, 0);
    checkOutput("bounce_level_high_cycles", level_high - lh0, 0);

    // Long hold: one long pulse, counter saturates.
    l0 = long_seen;
    applyStimulus(1'b1, 1'b1, 200);
    checkOutput("long_pulse_count", long_seen - l0, 1);
    checkOutput("long_hold_saturated", hold_ms, HOLD_MAX);
    applyStimulus(1'b0, 1'b1, 40);

    // Power drop mid-hold, then recovery with the button still held.
    p0 = press_seen;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (press_seen != p0) found = 1;
    end
    checkOutput("pwr_press_accepted", found, 1);
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      applyStimulus(1'b1, 1'b1, 1);
      if (hold_ms == 3) found = 1;
    end
    checkOutput("pwr_hold_reached_3", found, 1);
    r0 = release_seen;
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("pwr_drop_level", btn_level, 0);
    checkOutput("pwr_drop_hold", hold_ms, 0);
    applyStimulus(1'b1, 1'b0, 5);
    checkOutput("pwr_drop_no_release", release_seen - r0, 0);
    p0 = press_seen;
    applyStimulus(1'b1, 1'b1, 40);
    checkOutput("pwr_repress_count", press_seen - p0, 1);
    applyStimulus(1'b0, 1'b1, 40);

    // Short release glitch while pressed is swallowed by RELEASE_WAIT.
    applyStimulus(1'b1, 1'b1, 40);
    p0 = press_seen;
    r0 = release_seen;
    ll0 = level_low;
    h0 = hold_ms;
    applyStimulus(1'b0, 1'b1, 12);
    applyStimulus(1'b1, 1'b1, 40);
    checkOutput("glitch_press_count", press_seen - p0, 0);
    checkOutput("glitch_release_count", release_seen - r0, 0);
    checkOutput("glitch_level_low_cycles", level_low - ll0, 0);
    checkOutput("glitch_hold_counting", (hold_ms > h0) ? 1 : 0, 1);
    applyStimulus(1'b0, 1'b1, 40);

    // Randomised button and power activity against the model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) != 0),
                    int'($urandom_range(1, 45)));
    end

    // Asynchronous reset in the middle of a hold.
    applyStimulus(1'b1, 1'b1, 60);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    @(negedge clk);
    modelReset();
    p0 = press_seen;
    r0 = release_seen;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 40);
    checkOutput("post_reset_no_press", press_seen - p0, 0);
    checkOutput("post_reset_no_release", release_seen - r0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
